// File: rtl/pw_lockout_ctrl.sv
// Password-check controller: opens the lock on a code match and enters a timed lockout
// after MAX_TRIES consecutive mismatches. Define LOCKOUT_ESCALATE_EN for doubling lockouts.
module pw_lockout_ctrl #(
  parameter int PW_WIDTH       = 16,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PW_WIDTH-1:0]            pw_in,
  input  logic [PW_WIDTH-1:0]            password,
  input  logic                           enb_cmp,
  input  logic                           rst_out,
  input  logic                           lock_req,
  output logic                           enb_lock,
  output logic                           gen_stop,
  output logic                           match_p,
  output logic                           err_p,
  output logic [$clog2(MAX_TRIES+1)-1:0] err_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OPEN    = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

  localparam int CW       = $clog2(MAX_TRIES + 1);
  localparam int BASE_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
`ifdef LOCKOUT_ESCALATE_EN
  localparam int TW = $clog2(BASE_MAX + 1) + 3;
`else
  localparam int TW = $clog2(BASE_MAX + 1);
`endif

  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_TRY    = CW'(MAX_TRIES - 1);

  logic [1:0]    state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [TW-1:0] lock_load;
  logic [CW-1:0] err_cnt_d;
  logic          match_d, err_d;
  logic          enb_cmp_q;
  logic          attempt;
  logic          pw_match;

  assign attempt  = enb_cmp & ~enb_cmp_q;
  assign pw_match = (pw_in == password);

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] lvl, lvl_d;
  logic       lock_enter;

  // Lockout length doubles per level; the level is sampled before it is bumped.
  assign lock_load  = (TW'(LOCKOUT_CYCLES) << lvl) - TW'(1);
  assign lock_enter = (state == IDLE) && (state_d == LOCKOUT);

  always_comb begin
    lvl_d = lvl;
    if (rst_out || match_d) begin
      lvl_d = 2'd0;
    end else if (lock_enter && (lvl != 2'd3)) begin
      lvl_d = lvl + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl <= 2'd0;
    end else begin
      lvl <= lvl_d;
    end
  end
`else
  assign lock_load = TW'(LOCKOUT_CYCLES - 1);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state;
    timer_d   = timer;
    err_cnt_d = err_cnt;
    match_d   = 1'b0;
    err_d     = 1'b0;

    case (state)
      IDLE: begin
        if (rst_out) begin
          err_cnt_d = '0;
        end else if (attempt) begin
          if (pw_match) begin
            state_d   = OPEN;
            err_cnt_d = '0;
            match_d   = 1'b1;
            timer_d   = UNLOCK_LOAD;
          end else if (err_cnt == LAST_TRY) begin
            state_d   = LOCKOUT;
            err_cnt_d = '0;
            err_d     = 1'b1;
            timer_d   = lock_load;
          end else begin
            err_cnt_d = err_cnt + CW'(1);
            err_d     = 1'b1;
          end
        end
      end

      OPEN: begin
        if (rst_out || lock_req) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer - TW'(1);
        end
      end

      LOCKOUT: begin
        if (rst_out) begin
          state_d   = IDLE;
          timer_d   = '0;
          err_cnt_d = '0;
        end else if (timer == '0) begin
          state_d   = IDLE;
          err_cnt_d = '0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        err_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      enb_cmp_q <= 1'b0;
      enb_lock  <= 1'b0;
      gen_stop  <= 1'b0;
      match_p   <= 1'b0;
      err_p     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_d;
      timer     <= timer_d;
      enb_cmp_q <= enb_cmp;
      enb_lock  <= (state_d == OPEN);
      gen_stop  <= (state_d == LOCKOUT);
      match_p   <= match_d;
      err_p     <= err_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_pw_lockout_ctrl.sv
// Scoreboard bench for pw_lockout_ctrl: each queue entry holds one cycle of stimulus
// plus the outputs expected after the following rising edge.
module tb_pw_lockout_ctrl;

  localparam int          UNL = 5;
  localparam logic [15:0] PW  = 16'hA5C3;
  localparam logic [15:0] BAD = 16'h0000;

  logic        clk, reset;
  logic [15:0] pw_in, password;
  logic        enb_cmp, rst_out, lock_req;
  logic        enb_lock, gen_stop, match_p, err_p;
  logic [1:0]  err_cnt;
  logic [5:0]  obs;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        cmp;
    logic        rso;
    logic        lrq;
    logic [15:0] pw;
    logic [5:0]  v;
    string       tag;
  } ent_t;

  ent_t sbq[$];

  pw_lockout_ctrl #(
    .PW_WIDTH(16), .MAX_TRIES(3), .LOCKOUT_CYCLES(8), .UNLOCK_CYCLES(UNL)
  ) dut (
    .clk(clk), .reset(reset), .pw_in(pw_in), .password(password),
    .enb_cmp(enb_cmp), .rst_out(rst_out), .lock_req(lock_req),
    .enb_lock(enb_lock), .gen_stop(gen_stop), .match_p(match_p),
    .err_p(err_p), .err_cnt(err_cnt)
  );

  assign obs = {enb_lock, gen_stop, match_p, err_p, err_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] o(input logic el, input logic gs, input logic mp,
                                   input logic ep, input logic [1:0] ec);
    return {el, gs, mp, ep, ec};
  endfunction

  function automatic void push(input logic c, input logic r, input logic l,
                               input logic [15:0] p, input logic [5:0] v, input string t);
    ent_t e;
    e.cmp = c; e.rso = r; e.lrq = l; e.pw = p; e.v = v; e.tag = t;
    sbq.push_back(e);
  endfunction

  // Correct code from IDLE: lock open for UNL cycles, then closed.
  function automatic void push_open(input string t);
    push(1, 0, 0, PW, o(1, 0, 1, 0, 0), t);
    for (int i = 1; i < UNL; i++) push(0, 0, 0, PW, o(1, 0, 0, 0, 0), t);
    push(0, 0, 0, PW, o(0, 0, 0, 0, 0), t);
  endfunction

  // Three wrong attempts from err_cnt=0; last entry is the first lockout cycle.
  function automatic void push_attempts(input string t);
    push(1, 0, 0, BAD, o(0, 0, 0, 1, 1), t);
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 1), t);
    push(1, 0, 0, BAD, o(0, 0, 0, 1, 2), t);
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 2), t);
    push(1, 0, 0, BAD, o(0, 1, 0, 1, 0), t);
  endfunction

  // Full lockout of dur cycles; with poke, correct-code attempts are tried inside it.
  function automatic void push_lockout(input int dur, input bit poke, input string t);
    push_attempts(t);
    for (int i = 1; i < dur; i++)
      push(poke ? logic'(i[0]) : 1'b0, 0, 0, poke ? PW : BAD, o(0, 1, 0, 0, 0), t);
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 0), t);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, expected %b", obs, 6'b0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b, expected %b", obs, 6'b0);
    end
  endtask

  task automatic test_correct_code();
    ent_t e;
    push_open("correct_code");
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_wrong_codes();
    ent_t e;
    push_lockout(8, 1'b0, "three_wrong");
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_held_strobe();
    ent_t e;
    push(1, 0, 0, BAD, o(0, 0, 0, 1, 1), "held_first");
    for (int i = 1; i < 10; i++) push(1, 0, 0, BAD, o(0, 0, 0, 0, 1), "held_rest");
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 1), "held_release");
    push(1, 1, 0, BAD, o(0, 0, 0, 0, 0), "rso_beats_attempt");
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 0), "rso_idle");
    push_lockout(8, 1'b1, "attempt_in_lockout");
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_admin_clear();
    ent_t e;
    push_attempts("admin_enter");
    push(0, 0, 0, BAD, o(0, 1, 0, 0, 0), "admin_cyc2");
    push(0, 0, 0, BAD, o(0, 1, 0, 0, 0), "admin_cyc3");
    push(0, 1, 0, BAD, o(0, 0, 0, 0, 0), "admin_clear");
    push(0, 0, 0, BAD, o(0, 0, 0, 0, 0), "admin_idle");
    push(1, 0, 0, PW, o(1, 0, 1, 0, 0), "relock_open");
    push(0, 0, 0, PW, o(1, 0, 0, 0, 0), "relock_cyc2");
    push(0, 0, 1, PW, o(0, 0, 0, 0, 0), "relock_req");
    push(0, 0, 0, PW, o(0, 0, 0, 0, 0), "relock_idle");
    push(1, 0, 0, PW, o(1, 0, 1, 0, 0), "rso_open");
    push(0, 1, 0, PW, o(0, 0, 0, 0, 0), "rso_closes");
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        push(1, 0, 0, PW, o(1, 0, 1, 0, 0), "mid_open_enter");
        push(0, 0, 0, PW, o(1, 0, 0, 0, 0), "mid_open_hold");
      end else begin
        push_attempts("mid_lock_enter");
        push(0, 0, 0, BAD, o(0, 1, 0, 0, 0), "mid_lock_hold");
      end
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
        @(posedge clk); #1;
        n_chk++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
        end
      end
      // Assert reset well between edges: outputs must clear with no clock edge.
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if (obs !== 6'b0) begin
        n_fail++;
        $display("FAIL async_reset_phase%0d: got %b, expected %b", phase, obs, 6'b0);
      end
      #2 reset = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== 6'b0) begin
        n_fail++;
        $display("FAIL post_reset_phase%0d: got %b, expected %b", phase, obs, 6'b0);
      end
    end
  endtask

`ifdef LOCKOUT_ESCALATE_EN
  task automatic test_escalation();
    ent_t e;
    push(0, 1, 0, BAD, o(0, 0, 0, 0, 0), "esc_clear");
    push_lockout(8,  1'b0, "esc_8");
    push_lockout(16, 1'b0, "esc_16");
    push_lockout(32, 1'b0, "esc_32");
    push_lockout(64, 1'b0, "esc_64");
    push_lockout(64, 1'b0, "esc_sat");
    push_open("esc_match");
    push_lockout(8,  1'b0, "esc_restored");
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      enb_cmp = e.cmp; rst_out = e.rso; lock_req = e.lrq; pw_in = e.pw;
      @(posedge clk); #1;
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.tag, obs, e.v);
      end
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    pw_in    = 16'h0000;
    password = PW;
    enb_cmp  = 1'b0;
    rst_out  = 1'b0;
    lock_req = 1'b0;
    test_reset();
    test_correct_code();
    test_wrong_codes();
    test_held_strobe();
    test_admin_clear();
    test_reset_mid();
`ifdef LOCKOUT_ESCALATE_EN
    test_escalation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
